// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator.
//   Decodes instr (I/S/B/U/J, R as zero-immediate, everything else illegal),
//   sign-extends to XLEN and moves the result plus a sideband tag through a
//   STAGES-deep valid/ready pipeline with synchronous flush.  A saturating
//   counter tracks illegal instructions delivered downstream.
// Ports:
//   clk, n_rst               clock, async active-low reset
//   flush                    drop everything in flight at the next edge
//   in_valid/in_ready        upstream handshake; instr, in_tag payload
//   out_valid/out_ready      downstream handshake
//   imm_out/fmt_out/illegal_out/out_tag   delivered instruction fields
//   illegal_cnt, cnt_clr     saturating illegal counter and its clear
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt_out,
  output logic             illegal_out,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5,
                         FMT_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } stg_t;

  // ---------------- decode (combinational, ahead of stage 0) ----------------
  logic [31:0] imm32;
  stg_t        dec;

  always_comb begin
    imm32 = '0;
    dec   = '0;
    dec.fmt = FMT_X;
    dec.ill = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
          dec.fmt = FMT_I; dec.ill = 1'b0;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
        7'b0100011: begin
          dec.fmt = FMT_S; dec.ill = 1'b0;
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        7'b1100011: begin
          dec.fmt = FMT_B; dec.ill = 1'b0;
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec.fmt = FMT_U; dec.ill = 1'b0;
          imm32 = {instr[31:12], 12'b0};
        end
        7'b1101111: begin
          dec.fmt = FMT_J; dec.ill = 1'b0;
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        7'b0110011: begin
          dec.fmt = FMT_R; dec.ill = 1'b0;
        end
        default: ;
      endcase
    end
    // Widen the 32-bit immediate: fill with the sign, then drop in the low word.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    dec.tag       = in_tag;
  end

  // ---------------- pipeline ----------------
  logic [STAGES-1:0] vld_q;
  stg_t              stg_q   [STAGES];
  logic [STAGES-1:0] vld_src;
  stg_t              stg_src [STAGES];
  logic [STAGES-1:0] rdy;

  // Source of each stage: the decoder for stage 0, the previous stage otherwise.
  always_comb begin
    vld_src[0] = in_valid;
    stg_src[0] = dec;
    for (int k = 1; k < STAGES; k++) begin
      vld_src[k] = vld_q[k-1];
      stg_src[k] = stg_q[k-1];
    end
  end

  // ready_k = !valid_k || ready_{k+1}, folded from the output end so each
  // stage reads an accumulator rather than its neighbour's ready bit.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      r      = r | ~vld_q[k];
      rdy[k] = r;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_src[k];
          // Data only moves with a valid source so idle stages keep old contents.
          if (vld_src[k]) stg_q[k] <= stg_src[k];
        end
      end
      if (flush) vld_q <= '0;  // wins over any load in the same cycle
    end
  end

  assign in_ready    = rdy[0];
  assign out_valid   = vld_q[STAGES-1];
  assign imm_out     = stg_q[STAGES-1].imm;
  assign fmt_out     = stg_q[STAGES-1].fmt;
  assign illegal_out = stg_q[STAGES-1].ill;
  assign out_tag     = stg_q[STAGES-1].tag;

  // ---------------- illegal counter ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (out_valid && out_ready && illegal_out && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  localparam int XLEN = 64, STAGES = 3, TAG_W = 32, CNT_W = 3;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 0, n_rst = 0, flush = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
  logic [31:0] instr = 0;
  logic [TAG_W-1:0] in_tag = 0;
  logic in_ready, out_valid, illegal_out;
  logic [XLEN-1:0] imm_out;
  logic [2:0] fmt_out;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .fmt_out(fmt_out), .illegal_out(illegal_out), .out_tag(out_tag),
    .illegal_cnt(illegal_cnt), .cnt_clr(cnt_clr));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  int nchk = 0, nerr = 0;
  exp_t q[$];
  int mcnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: immediate as a signed integer built from weighted fields,
  // with the top field bit carrying negative weight.
  function automatic exp_t model(input logic [31:0] ins, input logic [TAG_W-1:0] tg);
    exp_t m;
    longint v;
    v = 0; m.fmt = 3'd7; m.ill = 1'b1;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
          m.fmt = 1; m.ill = 0;
          v = longint'(ins[30:20]) - (ins[31] ? 64'sd2048 : 64'sd0);
        end
        7'h23: begin
          m.fmt = 2; m.ill = 0;
          v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 64'sd2048 : 64'sd0);
        end
        7'h63: begin
          m.fmt = 3; m.ill = 0;
          v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
              - (ins[31] ? 64'sd4096 : 64'sd0);
        end
        7'h37, 7'h17: begin
          m.fmt = 4; m.ill = 0;
          v = longint'(ins[30:12]) * 4096 - (ins[31] ? 64'sh1_0000_0000 / 2 : 64'sd0);
        end
        7'h6F: begin
          m.fmt = 5; m.ill = 0;
          v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
              - (ins[31] ? 64'sd1048576 : 64'sd0);
        end
        7'h33: begin m.fmt = 0; m.ill = 0; end
        default: ;
      endcase
    end
    m.imm = v[XLEN-1:0];
    m.tag = tg;
    return m;
  endfunction

  // Compare process: handshakes are sampled mid-cycle, when they are stable
  // for the coming edge; the scoreboard is updated for that edge.
  logic stall_prev = 0;
  logic [127:0] held;
  always @(negedge clk) begin
    exp_t e;
    logic inc;
    if (!n_rst) begin
      q.delete(); mcnt = 0; stall_prev = 0;
      chk("reset_outs", {out_valid, imm_out, fmt_out, illegal_out, out_tag, illegal_cnt}, '0);
    end else begin
      inc = 0;
      chk("illegal_cnt", illegal_cnt, mcnt);
      if (stall_prev)
        chk("stall_hold", {out_valid, imm_out, fmt_out, illegal_out, out_tag}, held);
      if (out_valid) chk("out_has_pending", q.size() > 0, 1'b1);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", {imm_out, fmt_out, illegal_out, out_tag}, e);
        inc = e.ill;
      end
      stall_prev = out_valid && !out_ready && !flush;
      held = {out_valid, imm_out, fmt_out, illegal_out, out_tag};
      if (cnt_clr) mcnt = 0;
      else if (inc && mcnt < CMAX) mcnt++;
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back(model(instr, in_tag));
        chk("occupancy", q.size() <= STAGES, 1'b1);
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic directed(input logic [31:0] ins, input logic [63:0] eimm, input logic [2:0] efmt);
    int lat;
    out_ready = 1; in_valid = 1; instr = ins; in_tag = ins ^ 32'h5A5A_0000;
    chk("dir_in_ready", in_ready, 1'b1);
    cyc(); in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 12) begin cyc(); lat++; end
    chk("dir_latency", lat, STAGES);
    chk("dir_imm", imm_out, eimm);
    chk("dir_fmt", fmt_out, efmt);
    chk("dir_ill", illegal_out, efmt == 3'd7);
    cyc();
  endtask

  task automatic drain();
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (STAGES + 4) cyc();
    chk("drained", q.size(), 0);
  endtask

  localparam logic [6:0] OPS [11] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23,
                                      7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) < 8) r[6:0] = OPS[$urandom_range(0, 10)];
    return r;
  endfunction

  logic [31:0] s_ins [4];
  logic [63:0] s_imm [4];

  initial begin
    int j, first, acc;
    repeat (2) @(posedge clk);
    #1 n_rst = 1;

    // Model pinned to hand-computed values.
    chk("m_addi", model(32'hFFF00093, 0).imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("m_sw",   model(32'hFE112E23, 0).imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("m_beq",  model(32'hFE000CE3, 0).imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("m_lui",  model(32'h123450B7, 0).imm, 64'h0000_0000_1234_5000);
    chk("m_jal",  model(32'h0010006F, 0).imm, 64'h0000_0000_0000_0800);
    chk("m_lui64", model(32'h800000B7, 0).imm, 64'hFFFF_FFFF_8000_0000);
    chk("m_ill",  {model(32'h0000007F, 0).fmt, model(32'h0000007F, 0).ill}, {3'd7, 1'b1});

    // DUT against literals, with latency.
    directed(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    directed(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4);
    directed(32'h00000000, 64'h0, 3'd7);
    directed(32'h0000007F, 64'h0, 3'd7);
    chk("cnt_two", illegal_cnt, 2);

    // Back-to-back stream: four consecutive output cycles, no bubbles.
    s_ins = '{32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h0010006F};
    s_imm = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234_5000, 64'h800};
    j = 0; first = -1; out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin in_valid = 1; instr = s_ins[c]; in_tag = 100 + c; end
      else in_valid = 0;
      if (out_valid && j < 4) begin
        if (first < 0) first = c;
        chk("stream_imm", imm_out, s_imm[j]);
        chk("stream_tag", out_tag, 100 + j);
        chk("stream_contig", c, first + j);
        j++;
      end
      cyc();
    end
    chk("stream_count", j, 4);

    // Saturation, then clear.
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; instr = $urandom & 32'hFFFF_FFFC; in_tag = i; cyc();
    end
    in_valid = 0; repeat (STAGES + 2) cyc();
    chk("cnt_sat", illegal_cnt, CMAX);
    cnt_clr = 1; cyc(); cnt_clr = 0;
    chk("cnt_clr", illegal_cnt, 0);

    // Clear held while illegals are delivered: clear wins.
    cnt_clr = 1;
    for (int i = 0; i < 3; i++) begin in_valid = 1; instr = 32'h7F; cyc(); end
    in_valid = 0; repeat (STAGES + 2) cyc();
    cnt_clr = 0; cyc();
    chk("cnt_clr_wins", illegal_cnt, 0);

    // Stall: fills STAGES entries then back-pressures.
    out_ready = 0; acc = 0;
    for (int c = 0; c < STAGES + 5; c++) begin
      in_valid = 1; instr = rnd_instr(); in_tag = 200 + c;
      if (in_ready) acc++;
      cyc();
    end
    chk("stall_accepts", acc, STAGES);
    chk("stall_in_ready", in_ready, 1'b0);
    in_valid = 0;
    repeat (5) cyc();
    drain();

    // Flush a full pipe with an input offered in the flush cycle.
    out_ready = 0;
    for (int c = 0; c < STAGES + 2; c++) begin
      in_valid = 1; instr = rnd_instr(); in_tag = 300 + c; cyc();
    end
    out_ready = 1; flush = 1; in_valid = 1; instr = 32'h00100093; in_tag = 32'hDEAD;
    cyc();
    flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    for (int c = 0; c < STAGES + 2; c++) begin
      chk("flush_no_output", out_valid, 1'b0);
      cyc();
    end

    // Randomised traffic with flushes, clears and one mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      cnt_clr   = ($urandom_range(0, 99) < 2);
      instr     = rnd_instr();
      in_tag    = $urandom;
      if (c == 1500) begin
        n_rst = 0; cyc(); cyc(); n_rst = 1;
      end
      cyc();
    end
    cnt_clr = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
